// File: rtl/mem_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : datapath_defs
//  Purpose   : Shared definitions for the memory sequencer: FSM state
//              encodings, instruction width and default bus widths.
//  Revision  : 1.0  initial release
// ============================================================================
package datapath_defs;

    localparam int INS_W        = 32;
    localparam int c_ADDR_W_DEF = 64;
    localparam int c_DATA_W_DEF = 64;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_COMMIT = 3'd4;
    localparam logic [2:0] c_ST_ERR    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_FETCH  = c_ST_FETCH,
        ST_DECODE = c_ST_DECODE,
        ST_MEM    = c_ST_MEM,
        ST_COMMIT = c_ST_COMMIT,
        ST_ERR    = c_ST_ERR
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface : mem_seq_ctrl_if
//  Purpose   : Unified memory port shared by instruction fetch and data
//              load/store. master = sequencer, slave = memory model.
//  Revision  : 1.0  initial release
// ============================================================================
interface mem_seq_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_rdata, m_ready
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        output m_rdata, m_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_seq_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
//  Module    : mem_watchdog
//  Purpose   : Counts cycles a memory request waits without m_ready and
//              flags expiry on the wait cycle that brings the count to
//              TIMEOUT_CYCLES. Only built when MEM_TIMEOUT_EN is defined.
//  Revision  : 1.0  initial release
// ============================================================================
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic clk,
    input  wire logic rst,      // asynchronous, active-low
    input  wire logic i_clear,
    input  wire logic i_wait,
    output logic      o_expire
);
    localparam int c_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    // Wait counter: cleared outside request states, bumped on every stalled cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_wait) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_wait && (r_count == c_LIMIT);
endmodule
`default_nettype wire

// File: rtl/mem_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : mem_seq_ctrl
//  Purpose   : Multi-cycle sequencer sharing one memory port between
//              instruction fetch and data access; pulses commit once per
//              instruction. Optional request timeout: MEM_TIMEOUT_EN.
//  Revision  : 1.0  initial release
// ============================================================================
module mem_seq_ctrl
    import datapath_defs::*;
#(
    parameter int ADDR_W         = c_ADDR_W_DEF,
    parameter int DATA_W         = c_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic              clk,
    input  wire logic              rst,      // asynchronous, active-low
    input  wire logic [ADDR_W-1:0] if_addr,
    output logic      [INS_W-1:0]  ins,
    input  wire logic [ADDR_W-1:0] d_addr,
    input  wire logic [DATA_W-1:0] d_wdata,
    input  wire logic              d_read,
    input  wire logic              d_write,
    output logic      [DATA_W-1:0] d_rdata,
    output logic                   commit,
    output logic                   err,
    mem_seq_ctrl_if.master         mem
);
    state_t            r_state;
    state_t            w_state_next;
    logic              w_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_commit;
    logic              w_expire;

`ifdef MEM_TIMEOUT_EN
    mem_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (~w_req),
        .i_wait   (w_req & ~mem.m_ready),
        .o_expire (w_expire)
    );
    assign err = (r_state == ST_ERR);
`else
    assign w_expire = 1'b0;
    assign err      = 1'b0;
`endif

    // State register; reset drops any in-flight request immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and request decode; request fields depend only on state and datapath inputs
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_req  = 1'b1;
                w_addr = if_addr;
                if (mem.m_ready) begin
                    w_state_next = ST_DECODE;
                end else if (w_expire) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_DECODE: begin
                w_state_next = (d_read || d_write) ? ST_MEM : ST_COMMIT;
            end
            ST_MEM: begin
                w_req   = 1'b1;
                w_we    = d_write;
                w_addr  = d_addr;
                w_wdata = d_wdata;
                if (mem.m_ready) begin
                    w_state_next = ST_COMMIT;
                end else if (w_expire) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_ERR: begin
                w_state_next = ST_ERR;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Capture registers: instruction on fetch completion, load data on read-only completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ins     <= '0;
            d_rdata <= '0;
        end else begin
            if (r_state == ST_FETCH && mem.m_ready) begin
                ins <= mem.m_rdata[INS_W-1:0];
            end
            if (r_state == ST_MEM && mem.m_ready && d_read && !d_write) begin
                d_rdata <= mem.m_rdata;
            end
        end
    end

    assign mem.m_req   = w_req;
    assign mem.m_we    = w_we;
    assign mem.m_addr  = w_addr;
    assign mem.m_wdata = w_wdata;
    assign commit      = w_commit;
endmodule
`default_nettype wire

// File: tb/tb_mem_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : tb_mem_seq_ctrl
//  Purpose   : Self-checking bench for mem_seq_ctrl: table of instructions,
//              random instructions, reset during a data access and, with
//              MEM_TIMEOUT_EN, the request timeout.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_mem_seq_ctrl;
    import datapath_defs::*;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       ins;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_read;
    logic              d_write;
    logic [DATA_W-1:0] d_rdata;
    logic              commit;
    logic              err;

    mem_seq_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    mem_seq_ctrl #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .if_addr (if_addr),
        .ins     (ins),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_read  (d_read),
        .d_write (d_write),
        .d_rdata (d_rdata),
        .commit  (commit),
        .err     (err),
        .mem     (mem_bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state: what ins / d_rdata must hold between instructions
    logic [31:0] mdl_ins;
    logic [63:0] mdl_rdata;

    typedef struct {
        logic [63:0] if_addr;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        logic        rd;
        logic        wr;
        int          fw;          // fetch wait cycles
        int          mw;          // data wait cycles
        logic [63:0] fetch_data;
        logic [63:0] mem_data;
        logic [31:0] exp_ins;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Runs one instruction starting at a negedge in FETCH; the expected cycle
    // schedule comes from the wait counts: fetch, decode, [mem], commit.
    task automatic run_instr(input vec_t v);
        int  nf;
        int  nm;
        int  total;
        bit  mem_op;
        bit  ld;
        logic [31:0] e_ins;
        logic [63:0] e_rd;
        nf     = v.fw + 1;
        mem_op = v.rd | v.wr;
        ld     = v.rd & ~v.wr;
        nm     = mem_op ? v.mw + 1 : 0;
        total  = nf + 1 + nm + 1;
        if_addr = v.if_addr;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        d_read  = v.rd;
        d_write = v.wr;
        for (int k = 0; k < total; k++) begin
            #1;
            e_ins = (k >= nf) ? v.fetch_data[31:0] : mdl_ins;
            e_rd  = (ld && k >= nf + 1 + nm) ? v.mem_data : mdl_rdata;
            chk("ins", {32'h0, ins}, {32'h0, e_ins});
            chk("d_rdata", d_rdata, e_rd);
            if (k < nf) begin
                chk("fetch_req", {63'h0, mem_bus.m_req}, 64'd1);
                chk("fetch_we", {63'h0, mem_bus.m_we}, 64'd0);
                chk("fetch_addr", mem_bus.m_addr, v.if_addr);
                chk("fetch_commit", {63'h0, commit}, 64'd0);
                mem_bus.m_ready = (k == nf - 1);
                mem_bus.m_rdata = (k == nf - 1) ? v.fetch_data : rnd64();
            end else if (k > nf && k < nf + 1 + nm) begin
                chk("mem_req", {63'h0, mem_bus.m_req}, 64'd1);
                chk("mem_we", {63'h0, mem_bus.m_we}, {63'h0, v.wr});
                chk("mem_addr", mem_bus.m_addr, v.d_addr);
                chk("mem_wdata", mem_bus.m_wdata, v.d_wdata);
                chk("mem_commit", {63'h0, commit}, 64'd0);
                mem_bus.m_ready = (k == nf + nm);
                mem_bus.m_rdata = (k == nf + nm) ? v.mem_data : rnd64();
            end else begin
                // decode or commit: no request, junk on the bus must be ignored
                chk("idle_req", {63'h0, mem_bus.m_req}, 64'd0);
                chk("idle_addr", mem_bus.m_addr, 64'd0);
                chk("idle_wdata", mem_bus.m_wdata, 64'd0);
                chk("commit", {63'h0, commit}, (k == total - 1) ? 64'd1 : 64'd0);
                if (k == total - 1) begin
                    chk("final_ins", {32'h0, ins}, {32'h0, v.exp_ins});
                    chk("final_rdata", d_rdata, v.exp_rdata);
                    chk("err", {63'h0, err}, 64'd0);
                end
                mem_bus.m_ready = 1'($urandom_range(0, 1));
                mem_bus.m_rdata = rnd64();
            end
            @(negedge clk);
        end
        mdl_ins = v.fetch_data[31:0];
        if (ld) mdl_rdata = v.mem_data;
    endtask

    // Asserts reset at a negedge, checks reset values, releases; returns at the first FETCH negedge
    task automatic do_reset();
        rst = 1'b0;
        mem_bus.m_ready = 1'b0;
        #1;
        chk("rst_ins", {32'h0, ins}, 64'd0);
        chk("rst_rdata", d_rdata, 64'd0);
        chk("rst_commit", {63'h0, commit}, 64'd0);
        chk("rst_req", {63'h0, mem_bus.m_req}, 64'd0);
        chk("rst_we", {63'h0, mem_bus.m_we}, 64'd0);
        chk("rst_addr", mem_bus.m_addr, 64'd0);
        chk("rst_wdata", mem_bus.m_wdata, 64'd0);
        chk("rst_err", {63'h0, err}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_after_rst_req", {63'h0, mem_bus.m_req}, 64'd0);
        @(negedge clk);
        mdl_ins   = '0;
        mdl_rdata = '0;
    endtask

    initial begin
        vec_t v;
        rst = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_read = 1'b0; d_write = 1'b0;
        mem_bus.m_ready = 1'b0;
        mem_bus.m_rdata = '0;

        //            if_addr  d_addr  d_wdata rd wr fw mw  fetch_data              mem_data                exp_ins       exp_rdata
        tbl[0] = '{64'h0,  64'h0,  64'h0,  0, 0, 0, 0, 64'h11112222_00000013, 64'h0,                 32'h00000013, 64'h0};
        tbl[1] = '{64'h1,  64'h0,  64'h0,  0, 0, 0, 0, 64'h33334444_00a00093, 64'h0,                 32'h00a00093, 64'h0};
        tbl[2] = '{64'h2,  64'h40, 64'h0,  1, 0, 0, 2, 64'h0000000000043003, 64'hDEADBEEF_CAFEF00D, 32'h00043003, 64'hDEADBEEF_CAFEF00D};
        tbl[3] = '{64'h3,  64'h10, 64'h5,  0, 1, 0, 0, 64'h0000000000503823, 64'h5555AAAA_5555AAAA, 32'h00503823, 64'hDEADBEEF_CAFEF00D};
        tbl[4] = '{64'h4,  64'h18, 64'h7,  1, 1, 0, 1, 64'h00000000007C3C23, 64'h12345678_9ABCDEF0, 32'h007C3C23, 64'hDEADBEEF_CAFEF00D};
        tbl[5] = '{64'h5,  64'h0,  64'h0,  0, 0, 3, 0, 64'hFFFFFFFF_00000033, 64'h0,                 32'h00000033, 64'hDEADBEEF_CAFEF00D};
        tbl[6] = '{64'h6,  64'h20, 64'h0,  1, 0, 1, 1, 64'h0000000000023083, 64'h01234567_89ABCDEF, 32'h00023083, 64'h01234567_89ABCDEF};

        @(negedge clk);
        do_reset();

        // Back-to-back zero-wait non-memory instructions: commit every 3rd cycle
        for (int i = 0; i < 3; i++) begin
            v = tbl[0];
            v.fetch_data = {32'h0, 32'h00000013 + 32'(i)};
            v.exp_ins    = 32'h00000013 + 32'(i);
            run_instr(v);
        end

        for (int i = 0; i < 7; i++) run_instr(tbl[i]);

        // Random instructions checked against the reference state
        for (int i = 0; i < 40; i++) begin
            v.if_addr    = 64'(i + 100);
            v.d_addr     = rnd64();
            v.d_wdata    = rnd64();
            v.rd         = 1'($urandom_range(0, 1));
            v.wr         = 1'($urandom_range(0, 2) == 0);
            v.fw         = int'($urandom_range(0, 2));
            v.mw         = int'($urandom_range(0, 2));
            v.fetch_data = rnd64();
            v.mem_data   = rnd64();
            v.exp_ins    = v.fetch_data[31:0];
            v.exp_rdata  = (v.rd && !v.wr) ? v.mem_data : mdl_rdata;
            run_instr(v);
        end

        // Reset while a load waits in MEM
        if_addr = 64'h77; d_addr = 64'h80; d_wdata = 64'h0; d_read = 1'b1; d_write = 1'b0;
        #1;
        mem_bus.m_ready = 1'b1;
        mem_bus.m_rdata = 64'h0BADF00D_AABBCCDD;
        @(negedge clk);            // decode
        mem_bus.m_ready = 1'b0;
        @(negedge clk);            // first MEM cycle
        @(negedge clk);            // still waiting
        #1;
        chk("mid_mem_req", {63'h0, mem_bus.m_req}, 64'd1);
        chk("mid_mem_addr", mem_bus.m_addr, 64'h80);
        rst = 1'b0;
        #1;
        chk("abort_req", {63'h0, mem_bus.m_req}, 64'd0);
        chk("abort_ins", {32'h0, ins}, 64'd0);
        chk("abort_rdata", d_rdata, 64'd0);
        chk("abort_commit", {63'h0, commit}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            mem_bus.m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            chk("held_commit", {63'h0, commit}, 64'd0);
            chk("held_req", {63'h0, mem_bus.m_req}, 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        mem_bus.m_ready = 1'b0;
        @(negedge clk);
        mdl_ins = '0;
        mdl_rdata = '0;
        v = tbl[0];
        v.if_addr = 64'h1234;
        run_instr(v);

`ifdef MEM_TIMEOUT_EN
        // Fetch that never completes: err after TMO wait cycles, bus goes quiet
        do_reset();
        if_addr = 64'h99; d_read = 1'b0; d_write = 1'b0;
        mem_bus.m_ready = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            #1;
            chk("tmo_wait_req", {63'h0, mem_bus.m_req}, 64'd1);
            chk("tmo_wait_err", {63'h0, err}, 64'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("tmo_err", {63'h0, err}, 64'd1);
            chk("tmo_req", {63'h0, mem_bus.m_req}, 64'd0);
            chk("tmo_commit", {63'h0, commit}, 64'd0);
            mem_bus.m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        do_reset();
        run_instr(tbl[0]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_seq_ctrl.md
# mem_seq_ctrl

Multi-cycle sequencer that lets the single-cycle 64-bit datapath share one unified memory port for both instruction fetch and data load/store. It fetches an instruction, holds it stable for the datapath's combinational decode, performs the optional data access, then pulses `commit` so the PC and register file update exactly once per instruction. It sits between the datapath top level and the memory model/controller.

## Interface
Parameters:
- `ADDR_W`, 64, memory address width (PC is a word address; +1 per instruction)
- `DATA_W`, 64, memory data width
- `TIMEOUT_CYCLES`, 255, `m_ready` wait limit per request (used only with `MEM_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_addr`  in  ADDR_W  fetch address (datapath PC)
- `ins`  out  32  latched instruction fed to the datapath
- `d_addr`  in  ADDR_W  data address (ALU result)
- `d_wdata`  in  DATA_W  store data (register read port 2)
- `d_read`  in  1  datapath MemRead
- `d_write`  in  1  datapath MemWrite
- `d_rdata`  out  DATA_W  latched load data, held for MemtoReg mux
- `commit`  out  1  one-cycle pulse; gates PC update and register write enable
- `m_req`  out  1  memory request valid
- `m_we`  out  1  1 = write, 0 = read
- `m_addr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_rdata`  in  DATA_W  memory read data, valid when `m_ready`
- `m_ready`  in  1  request completes this cycle
- `err`  out  1  sticky timeout error

## Operation
- FSM states: IDLE, FETCH, DECODE, MEM, COMMIT, ERR.
- IDLE: entered on reset; leaves to FETCH on the first clock after `rst` deasserts.
- FETCH: `m_req`=1, `m_we`=0, `m_addr`=`if_addr`. On `m_ready`: `ins` <= `m_rdata[31:0]`, go DECODE.
- DECODE: no request; control settles on new `ins`. If `d_read|d_write` go MEM, else go COMMIT.
- MEM: `m_req`=1, `m_we`=`d_write`, `m_addr`=`d_addr`, `m_wdata`=`d_wdata`. On `m_ready`: if read, `d_rdata` <= `m_rdata`; go COMMIT.
- `d_read` and `d_write` both high: write wins, `d_rdata` not updated.
- COMMIT: `commit`=1 for exactly one cycle; go FETCH.
- `m_req`/`m_we`/`m_addr`/`m_wdata` are decoded from the state register and stable inputs only. No combinational path from `m_ready` to `m_req`. Request fields stay constant until `m_ready`.
- `m_ready` is ignored while `m_req`=0.
- `m_addr`/`m_wdata` are 0 when `m_req`=0.

## Timing
- Reset values (async, `rst`=0): state IDLE, `ins`=0, `d_rdata`=0, `commit`=0, `m_req`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0, `err`=0.
- Zero-wait memory (`m_ready` high in the request cycle):
  - non-memory instruction: 3 cycles (FETCH, DECODE, COMMIT)
  - load/store: 4 cycles
- Each low-`m_ready` cycle adds 1 cycle to FETCH or MEM.
- `ins` changes only on a FETCH completion edge. `d_rdata` changes only on a MEM-read completion edge.
- Reset asserted mid-request: request dropped immediately, no `commit`. The memory side must tolerate the abandoned request.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A wait counter clears on entry to FETCH/MEM and increments each cycle with `m_req`=1 and `m_ready`=0.
  - When the counter reaches `TIMEOUT_CYCLES`, the FSM goes to ERR: `m_req`=0, `err`=1, no `commit`. ERR is held until reset.
- `MEM_TIMEOUT_EN` undefined: no counter; the FSM waits indefinitely; `err` tied 0; `TIMEOUT_CYCLES` unused.

## Structure
- Shared package/header `datapath_defs`: state encodings (3-bit localparams), `INS_W`=32, default `ADDR_W`/`DATA_W`.
- One sub-module, `mem_watchdog`: wait counter plus compare, instantiated only under `MEM_TIMEOUT_EN`.
- FSM and capture registers live in `mem_seq_ctrl`.

## Test plan
- Reset release, `m_ready`=1 always, `d_read`=`d_write`=0, `if_addr`=0 → `m_req` first high 1 cycle after IDLE; `ins` = `m_rdata[31:0]`; `commit` pulses every 3rd cycle.
- Load with `d_addr`=0x40, `m_rdata`=0xDEADBEEF_CAFEF00D in MEM, `m_ready` delayed 2 cycles → `m_we`=0, `m_addr`=0x40 held 3 cycles; `d_rdata`=0xDEADBEEFCAFEF00D; `commit` 6 cycles after FETCH start.
- Store with `d_write`=1, `d_addr`=0x10, `d_wdata`=5 → one request with `m_we`=1, `m_wdata`=5; `d_rdata` unchanged; single `commit`.
- `rst` asserted while in MEM with `m_ready`=0 → `m_req`=0 in the same cycle; no `commit`; `ins`=0; restart fetches `if_addr` cleanly.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `m_ready` stuck 0 in FETCH → `err`=1 after 4 wait cycles; `m_req`=0; no further requests until reset.
